if_fetch_unit: RTL and testbench

- Instruction-fetch stage producer for the IF/ID pipeline register.
- Owns the fetch PC and issues one-outstanding requests to instruction memory over a req/ack handshake.
- Delivers instruction_F / PC to IF/ID and drives IF_ID_wr / IF_ID_flush.
- Honours ID-stage stalls and late branch/jump redirects.

---
 rtl/if_fetch_unit.sv | 138 +++++++++++++
 tb/tb_if_fetch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one imem request
// outstanding, and feeds the IF/ID register with bypass, skid buffer and redirect kill.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_D,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_F,
  output logic [31:0] PC,
  output logic        IF_ID_wr,
  output logic        IF_ID_flush
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;

  logic [31:0] redirect_tgt;
  logic [31:0] fetch_pc_inc;
  logic        bypass;
  logic        full_deliver;

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign fetch_pc_inc = fetch_pc_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_addr_d  = req_addr_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    case (state_q)
      S_IDLE: begin
        state_d    = S_WAIT;
        req_addr_d = fetch_pc_q;
        if (redirect) begin
          fetch_pc_d = redirect_tgt;
          req_addr_d = redirect_tgt;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          fetch_pc_d = redirect_tgt;
          // Without an ack the killed request stays on the bus until it completes.
          if (imem_ack) begin
            req_addr_d = redirect_tgt;
          end else begin
            state_d = S_DROP;
          end
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_inc;
          if (!stall_D) begin
            req_addr_d = fetch_pc_inc;
          end else begin
            buf_instr_d = imem_rdata;
            buf_pc_d    = fetch_pc_inc;
            state_d     = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (redirect) begin
          fetch_pc_d = redirect_tgt;
          req_addr_d = redirect_tgt;
          state_d    = S_WAIT;
        end else if (!stall_D) begin
          req_addr_d = fetch_pc_q;
          state_d    = S_WAIT;
        end
      end
      S_DROP: begin
        if (redirect) begin
          fetch_pc_d = redirect_tgt;
        end
        if (imem_ack) begin
          req_addr_d = redirect ? redirect_tgt : fetch_pc_q;
          state_d    = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      req_addr_q  <= RESET_PC;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= RESET_PC + 32'd4;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_addr_q  <= req_addr_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

  // Response goes straight to IF/ID when ID can take it; otherwise it lands in the buffer.
  assign bypass       = (state_q == S_WAIT) && imem_ack && !redirect && !stall_D;
  assign full_deliver = (state_q == S_FULL) && !redirect && !stall_D;

  always_comb begin
    imem_req      = (state_q == S_WAIT) || (state_q == S_DROP);
    imem_addr     = req_addr_q;
    IF_ID_wr      = bypass || full_deliver;
    IF_ID_flush   = redirect || (!(bypass || full_deliver) && !stall_D);
    instruction_F = NOP_INSTR;
    PC            = fetch_pc_inc;
    if (bypass) begin
      instruction_F = imem_rdata;
    end else if (state_q == S_FULL) begin
      instruction_F = buf_instr_q;
      PC            = buf_pc_q;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: streaming, stall buffering, redirect kill, wrap and reset.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall_D;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_F;
  logic [31:0] PC;
  logic        IF_ID_wr;
  logic        IF_ID_flush;

  int checks;
  int failures;

  if_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_D      (stall_D),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instruction_F(instruction_F),
    .PC           (PC),
    .IF_ID_wr     (IF_ID_wr),
    .IF_ID_flush  (IF_ID_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_D = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    step();
    step();
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (imem_addr !== 32'h0000_3000) begin failures++; $display("FAIL reset_addr got=%h exp=00003000", imem_addr); end
    checks++; if (IF_ID_wr !== 1'b0) begin failures++; $display("FAIL reset_wr got=%b exp=0", IF_ID_wr); end
    checks++; if (IF_ID_flush !== 1'b1) begin failures++; $display("FAIL reset_flush got=%b exp=1", IF_ID_flush); end
    checks++; if (instruction_F !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=00000000", instruction_F); end
    checks++; if (PC !== 32'h0000_3004) begin failures++; $display("FAIL reset_pc got=%h exp=00003004", PC); end
    $display("reset: req=%b addr=%h flush=%b pc=%h", imem_req, imem_addr, IF_ID_flush, PC);
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr [3];
    logic [31:0] exp_pc [3];
    exp_addr[0] = 32'h3000; exp_addr[1] = 32'h3004; exp_addr[2] = 32'h3008;
    exp_pc[0]   = 32'h3004; exp_pc[1]   = 32'h3008; exp_pc[2]   = 32'h300C;
    step();
    rst_n = 1'b1; imem_ack = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0 || IF_ID_flush !== 1'b1) begin failures++; $display("FAIL idle_cycle req=%b flush=%b exp req=0 flush=1", imem_req, IF_ID_flush); end
    for (int i = 0; i < 3; i++) begin
      step();
      imem_rdata = 32'hA000_0000 + i;
      @(negedge clk);
      checks++; if (imem_addr !== exp_addr[i]) begin failures++; $display("FAIL stream_addr%0d got=%h exp=%h", i, imem_addr, exp_addr[i]); end
      checks++; if (IF_ID_wr !== 1'b1 || IF_ID_flush !== 1'b0) begin failures++; $display("FAIL stream_wr%0d wr=%b flush=%b exp wr=1 flush=0", i, IF_ID_wr, IF_ID_flush); end
      checks++; if (PC !== exp_pc[i]) begin failures++; $display("FAIL stream_pc%0d got=%h exp=%h", i, PC, exp_pc[i]); end
      checks++; if (instruction_F !== 32'hA000_0000 + i) begin failures++; $display("FAIL stream_instr%0d got=%h exp=%h", i, instruction_F, 32'hA000_0000 + i); end
      $display("stream: addr=%h pc=%h instr=%h wr=%b", imem_addr, PC, instruction_F, IF_ID_wr);
    end
  endtask

  task automatic test_stall();
    // WAIT at 300C; ack while stalled fills the buffer.
    step();
    stall_D = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBBBB_000C;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h300C || IF_ID_wr !== 1'b0 || IF_ID_flush !== 1'b0) begin failures++; $display("FAIL stall_ack addr=%h wr=%b flush=%b exp 0000300c 0 0", imem_addr, IF_ID_wr, IF_ID_flush); end
    for (int i = 0; i < 2; i++) begin
      step();
      imem_ack = 1'b0; imem_rdata = 32'h0;
      @(negedge clk);
      checks++; if (imem_req !== 1'b0 || IF_ID_wr !== 1'b0 || IF_ID_flush !== 1'b0) begin failures++; $display("FAIL stall_full%0d req=%b wr=%b flush=%b exp 0 0 0", i, imem_req, IF_ID_wr, IF_ID_flush); end
    end
    step();
    stall_D = 1'b0;
    @(negedge clk);
    checks++; if (IF_ID_wr !== 1'b1 || PC !== 32'h3010 || instruction_F !== 32'hBBBB_000C) begin failures++; $display("FAIL stall_release wr=%b pc=%h instr=%h exp 1 00003010 bbbb000c", IF_ID_wr, PC, instruction_F); end
    step();
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3010 || IF_ID_wr !== 1'b0) begin failures++; $display("FAIL stall_next req=%b addr=%h wr=%b exp 1 00003010 0", imem_req, imem_addr, IF_ID_wr); end
    checks++; if (IF_ID_flush !== 1'b1) begin failures++; $display("FAIL stall_bubble flush=%b exp=1", IF_ID_flush); end
    $display("stall: released buffered pc=00003010, next addr=%h", imem_addr);
  endtask

  task automatic test_redirect_drop();
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_4002;
    @(negedge clk);
    checks++; if (IF_ID_flush !== 1'b1 || IF_ID_wr !== 1'b0) begin failures++; $display("FAIL drop_enter flush=%b wr=%b exp 1 0", IF_ID_flush, IF_ID_wr); end
    step();
    redirect = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3010) begin failures++; $display("FAIL drop_hold req=%b addr=%h exp 1 00003010", imem_req, imem_addr); end
    step();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (IF_ID_wr !== 1'b0 || instruction_F !== 32'h0 || imem_addr !== 32'h3010) begin failures++; $display("FAIL drop_ack wr=%b instr=%h addr=%h exp 0 00000000 00003010", IF_ID_wr, instruction_F, imem_addr); end
    step();
    imem_rdata = 32'hCCCC_4000;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h4000 || IF_ID_wr !== 1'b1 || PC !== 32'h4004 || instruction_F !== 32'hCCCC_4000) begin failures++; $display("FAIL drop_resume addr=%h wr=%b pc=%h instr=%h exp 00004000 1 00004004 cccc4000", imem_addr, IF_ID_wr, PC, instruction_F); end
    $display("redirect_drop: resumed addr=%h pc=%h", imem_addr, PC);
  endtask

  task automatic test_redirect_ack();
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_5000; imem_rdata = 32'hEEEE_EEEE;
    @(negedge clk);
    checks++; if (IF_ID_flush !== 1'b1 || IF_ID_wr !== 1'b0 || instruction_F !== 32'h0) begin failures++; $display("FAIL redir_ack flush=%b wr=%b instr=%h exp 1 0 00000000", IF_ID_flush, IF_ID_wr, instruction_F); end
    step();
    redirect = 1'b0; imem_ack = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h5000) begin failures++; $display("FAIL redir_ack_next req=%b addr=%h exp 1 00005000", imem_req, imem_addr); end
    // Two redirects while draining: the later one must win.
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_6000;
    step();
    redirect_pc = 32'h0000_7000;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h5000) begin failures++; $display("FAIL drop_killed_addr got=%h exp=00005000", imem_addr); end
    step();
    redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    step();
    imem_rdata = 32'h7777_0000;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h7000 || PC !== 32'h7004 || IF_ID_wr !== 1'b1) begin failures++; $display("FAIL latest_redirect addr=%h pc=%h wr=%b exp 00007000 00007004 1", imem_addr, PC, IF_ID_wr); end
    $display("redirect_ack: latest target addr=%h", imem_addr);
  endtask

  task automatic test_redirect_full();
    step();
    stall_D = 1'b1; imem_rdata = 32'hF1F1_F1F1;
    step();
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_8000;
    @(negedge clk);
    checks++; if (IF_ID_flush !== 1'b1 || IF_ID_wr !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL full_redirect flush=%b wr=%b req=%b exp 1 0 0", IF_ID_flush, IF_ID_wr, imem_req); end
    step();
    redirect = 1'b0; stall_D = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h8888_8888;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h8000 || PC !== 32'h8004 || instruction_F !== 32'h8888_8888 || IF_ID_wr !== 1'b1) begin failures++; $display("FAIL full_redirect_next addr=%h pc=%h instr=%h wr=%b exp 00008000 00008004 88888888 1", imem_addr, PC, instruction_F, IF_ID_wr); end
    $display("redirect_full: buffered word dropped, addr=%h", imem_addr);
  endtask

  task automatic test_wrap();
    step();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0; imem_rdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if (imem_addr !== 32'hFFFF_FFFC || PC !== 32'h0 || IF_ID_wr !== 1'b1) begin failures++; $display("FAIL wrap_pc addr=%h pc=%h wr=%b exp fffffffc 00000000 1", imem_addr, PC, IF_ID_wr); end
    step();
    imem_ack = 1'b0;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin failures++; $display("FAIL wrap_next addr=%h req=%b exp 00000000 1", imem_addr, imem_req); end
    checks++; if (IF_ID_flush !== 1'b1) begin failures++; $display("FAIL wait_noack_flush got=%b exp=1", IF_ID_flush); end
    stall_D = 1'b1;
    #1;
    checks++; if (IF_ID_flush !== 1'b0 || IF_ID_wr !== 1'b0) begin failures++; $display("FAIL stall_hold flush=%b wr=%b exp 0 0", IF_ID_flush, IF_ID_wr); end
    $display("wrap: pc wrapped, next addr=%h", imem_addr);
  endtask

  task automatic test_reset_in_drop();
    step();
    stall_D = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_9000;
    step();
    redirect = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL drop_before_reset req=%b addr=%h exp 1 00000000", imem_req, imem_addr); end
    step();
    rst_n = 1'b0; imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h3000 || IF_ID_wr !== 1'b0 || IF_ID_flush !== 1'b1) begin failures++; $display("FAIL drop_reset req=%b addr=%h wr=%b flush=%b exp 0 00003000 0 1", imem_req, imem_addr, IF_ID_wr, IF_ID_flush); end
    checks++; if (instruction_F !== 32'h0 || PC !== 32'h3004) begin failures++; $display("FAIL drop_reset_data instr=%h pc=%h exp 00000000 00003004", instruction_F, PC); end
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin failures++; $display("FAIL after_reset req=%b addr=%h exp 1 00003000", imem_req, imem_addr); end
    $display("reset_in_drop: restart addr=%h", imem_addr);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_redirect_ack();
    test_redirect_full();
    test_wrap();
    test_reset_in_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
